// File: rtl/alu_rr_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Optional op counter is enabled by defining ALU_SCHED_STATS_EN.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } sched_state_e;

    localparam int ALU_LATENCY = 1;
    localparam int STATS_W     = 16;

endpackage

// File: rtl/alu_rr_sched_if.sv
// Client-facing request/response bundle of the ALU scheduler.
// master = client side, slave = scheduler side.
interface alu_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*2-1:0]      req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W:0]           rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request above ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);
    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (en && !gnt_any && req[ID_W'(idx)]) begin
                gnt[ID_W'(idx)] = 1'b1;
                gnt_idx         = ID_W'(idx);
                gnt_any         = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU among NUM_REQ clients.
// Define ALU_SCHED_STATS_EN to add the saturating op_count output.
//
// state | meaning
// IDLE  | arbitrate; winner's operands latched on the accept edge
// ISSUE | operands stable at the ALU; ALU registers its result
// WAIT  | alu_out valid; captured into rsp_data, rsp_valid rises
// RESP  | response held until rsp_ready
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_rr_sched_if.slave     bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W:0]   alu_out
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0] op_count
`endif
);
    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    alu_op_e           sel_q, sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              rsp_done;
`ifdef ALU_SCHED_STATS_EN
    logic [STATS_W-1:0] cnt_q, cnt_d;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .en      (state_q == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign rsp_done = (state_q == RESP) && rsp_valid_q && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= ADD;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ALU_SCHED_STATS_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ALU_SCHED_STATS_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef ALU_SCHED_STATS_EN
        cnt_d       = cnt_q;
`endif
        if (gnt_any) begin
            a_d   = bus.req_a[int'(gnt_idx)*DATA_W +: DATA_W];
            b_d   = bus.req_b[int'(gnt_idx)*DATA_W +: DATA_W];
            sel_d = alu_op_e'(bus.req_op[int'(gnt_idx)*2 +: 2]);
            id_d  = gnt_idx;
            ptr_d = gnt_idx;
        end
        if (state_q == WAIT) begin
            rsp_data_d  = alu_out;
            rsp_valid_d = 1'b1;
        end
        if (rsp_done) begin
            rsp_valid_d = 1'b0;
`ifdef ALU_SCHED_STATS_EN
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_sel       = sel_q;
`ifdef ALU_SCHED_STATS_EN
    assign op_count      = cnt_q;
`endif
endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed cases plus randomized traffic
// against a transaction-level model (grant order, 3-cycle latency, result values).
module tb_alu_rr_sched;
    import alu_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [1:0]        alu_sel;
    logic [DATA_W:0]   alu_out;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0]       op_count;
`endif

    alu_rr_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_out (alu_out)
`ifdef ALU_SCHED_STATS_EN
        ,
        .op_count(op_count)
`endif
    );

    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Registered ALU: one-cycle latency, same clock and reset as the scheduler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_out <= '0;
        else        alu_out <= alu_ref(alu_a, alu_b, alu_sel);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Transaction-level reference: one op in flight, response 3 cycles after
    // grant, next grant the cycle after the response handshake.
    typedef struct {
        int         id;
        logic [8:0] res;
        int         due;
    } exp_t;

    exp_t mq[$];
    int   cyc    = 0;
    int   m_free = 0;
    int   m_ptr  = NUM_REQ - 1;
    int   m_hs   = 0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] eg;
        int w;
        int j;
        if (!rst_n) begin
            mq.delete();
            m_ptr  = NUM_REQ - 1;
            m_free = 0;
            m_hs   = 0;
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef ALU_SCHED_STATS_EN
            check("rst_op_count", 32'(op_count), 32'd0);
`endif
        end else begin
            eg = '0;
            w  = -1;
            if (mq.size() == 0 && cyc >= m_free) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    j = (m_ptr + k) % NUM_REQ;
                    if (w < 0 && bus.req_valid[j]) w = j;
                end
            end
            if (w >= 0) eg[w] = 1'b1;
            check("grant", 32'(bus.req_ready), 32'(eg));
`ifdef ALU_SCHED_STATS_EN
            check("op_count", 32'(op_count), (m_hs > 65535) ? 32'hFFFF : 32'(m_hs));
`endif
            if (w >= 0) begin
                m_ptr = w;
                mq.push_back('{w, alu_ref(bus.req_a[w*DATA_W +: DATA_W],
                                          bus.req_b[w*DATA_W +: DATA_W],
                                          bus.req_op[w*2 +: 2]), cyc + 3});
            end
            if (mq.size() > 0 && cyc >= mq[0].due) begin
                check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("rsp_id", 32'(bus.rsp_id), 32'(mq[0].id));
                check("rsp_data", 32'(bus.rsp_data), 32'(mq[0].res));
                if (bus.rsp_ready) begin
                    void'(mq.pop_front());
                    m_free = cyc + 1;
                    m_hs++;
                end
            end else begin
                check("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
            end
        end
        cyc++;
    end

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        bus.req_a[id*DATA_W +: DATA_W] = a;
        bus.req_b[id*DATA_W +: DATA_W] = b;
        bus.req_op[id*2 +: 2]          = op;
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [8:0] exp, input string tag);
        logic [NUM_REQ-1:0] onehot;
        int  lat;
        bit  got;
        set_req(id, a, b, op);
        bus.req_valid[id] = 1'b1;
        onehot = '0;
        onehot[id] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                got = 1'b1;
                check({tag, "_gnt_vec"}, 32'(bus.req_ready), 32'(onehot));
            end
        end
        check({tag, "_granted"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
            else lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
        check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] g;
        int gid[5];
        int gcyc[5];
        int n;
        logic [ID_W-1:0] snap_id;
        logic [8:0]      snap_data;
        bit got;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Directed operations; rsp_ready high beforehand must be harmless.
        bus.rsp_ready = 1'b1;
        do_op(2, 8'hFF, 8'hFF, 2'd0, 9'h1FE, "add");
        do_op(1, 8'h05, 8'h0A, 2'd1, 9'h1FB, "sub");
        do_op(0, 8'hF0, 8'h3C, 2'd2, 9'h030, "and");
        do_op(3, 8'hF0, 8'h0F, 2'd3, 9'h0FF, "or");

        // All four requesting: pointer sits at 3, so order is 0,1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
        bus.req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            gid[i]  = -1;
            gcyc[i] = 0;
        end
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            g = bus.req_ready & bus.req_valid;
            if (g != 0) begin
                gid[n]  = $clog2(g);
                gcyc[n] = c;
                n++;
            end
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++)
                if (g[i]) set_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
        end
        bus.req_valid = '0;
        for (int i = 0; i < 5; i++) check("rr_order", 32'(gid[i]), 32'(i % NUM_REQ));
        for (int i = 1; i < 5; i++) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd4);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: response held for 5 cycles, no grant while waiting.
        bus.rsp_ready = 1'b0;
        set_req(1, 8'h12, 8'h34, 2'd0);
        bus.req_valid[1] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready[1]) got = 1'b1;
        end
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
        end
        check("bp_rsp_seen", 32'(got), 32'd1);
        check("bp_data", 32'(bus.rsp_data), 32'h046);
        snap_id   = bus.rsp_id;
        snap_data = bus.rsp_data;
        @(posedge clk); #1;
        set_req(2, 8'h81, 8'h7F, 2'd1);
        bus.req_valid[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hold_id", 32'(bus.rsp_id), 32'(snap_id));
            check("bp_hold_data", 32'(bus.rsp_data), 32'(snap_data));
            check("bp_no_grant", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("bp_next_grant", 32'(bus.req_ready), 32'b0100);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Randomized traffic checked by the reference model.
        acc = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    set_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
                    bus.req_valid[i] = ($urandom_range(0, 2) == 0);
                end else if (bus.req_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    set_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
                    bus.req_valid[i] = 1'b1;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Reset during WAIT: operation dropped, pointer back to NUM_REQ-1.
        set_req(0, 8'h0F, 8'h01, 2'd0);
        bus.req_valid[0] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready[0]) got = 1'b1;
        end
        check("mid_rst_granted", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_alu_b", 32'(alu_b), 32'd0);
        check("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("mid_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        set_req(0, 8'h11, 8'h22, 2'd3);
        set_req(1, 8'h33, 8'h44, 2'd2);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        check("post_rst_grant", 32'(bus.req_ready), 32'b0001);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = bus.req_ready;
            @(posedge clk); #1;
            if (g[1]) bus.req_valid[1] = 1'b0;
        end
        bus.req_valid = '0;
        repeat (6) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
Round-robin scheduler that shares the single registered 8-bit ALU (2-bit op select, 9-bit result, 1-cycle latency) between NUM_REQ requesters. It accepts one operation at a time via a valid/ready handshake, drives the ALU operand and select inputs from registers, and captures the ALU result after its one-cycle latency. It then returns the result with the requester ID over a backpressurable response channel. It sits between the client blocks and the ALU instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand width; the result is DATA_W+1 bits
ID_W, $clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept
req_a  in  NUM_REQ*DATA_W  packed operand A; slot i is bits [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  packed operand B
req_op  in  NUM_REQ*2  packed op code: 0 ADD, 1 SUB, 2 AND, 3 OR
alu_a  out  DATA_W  to ALU operand A
alu_b  out  DATA_W  to ALU operand B
alu_sel  out  2  to ALU select
alu_out  in  DATA_W+1  from ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of the requester that owns the result
rsp_data  out  DATA_W+1  captured ALU result

Behaviour:
- The reset rst_n is asynchronous and active-low. The clock is clk. The ALU shares the same clk and rst_n.
- Reset values: state IDLE, req_ready=0, alu_a=0, alu_b=0, alu_sel=0, rsp_valid=0, rsp_id=0, rsp_data=0, rr pointer=NUM_REQ-1 (requester 0 wins first).
- FSM states and transitions:
  - IDLE → ISSUE: when any req_valid is set.
  - ISSUE → WAIT: unconditional.
  - WAIT → RESP: unconditional.
  - RESP → IDLE: on rsp_valid && rsp_ready.
- Grant (IDLE only):
  - req_ready is combinational and one-hot.
  - It selects the first set req_valid searching from pointer+1 upward, with wrap-around.
  - req_ready is 0 in every other state.
- Accept edge (in IDLE, with winner w):
  - Latch req_a/req_b/req_op of w into alu_a/alu_b/alu_sel.
  - Latch w into the ID register.
  - Pointer becomes w.
- ISSUE: operands are stable; the ALU registers its result at the end of this cycle.
- WAIT:
  - alu_out is valid and is captured into rsp_data at the end of the cycle.
  - rsp_valid rises together with it.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready.
  - rsp_valid drops on the edge that completes the handshake.
- Latency and throughput:
  - Request accepted in cycle N → rsp_valid high in cycle N+3.
  - Minimum 4 cycles per operation; no overlap.
- alu_a, alu_b and alu_sel hold their last values outside ISSUE/WAIT. alu_out is ignored outside WAIT.
- Arithmetic is performed by the ALU; the scheduler passes the result through unmodified:
  - SUB wraps modulo 2^(DATA_W+1).
  - Bit DATA_W is 0 for AND/OR.
- Requester protocol:
  - A requester holds valid and payload until its ready is seen.
  - Deasserting valid before grant is allowed; the request is simply not served.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep valid asserted and are served in rotation.
- rsp_ready high before rsp_valid has no effect.
- Reset mid-operation: the in-flight operation is dropped, no response is issued, the FSM returns to IDLE, and the pointer is reset.

Optional Feature:
ALU_SCHED_STATS_EN:
- Defined:
  - Adds output port op_count (16 bits), reset 0.
  - Increments by 1 on each completed response handshake.
  - Saturates at 0xFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_sched_pkg:
  - alu_op_e enum: ADD=2'b00, SUB=2'b01, AND=2'b10, OR=2'b11.
  - sched_state_e enum: IDLE, ISSUE, WAIT, RESP.
  - Constants: ALU_LATENCY=1, STATS_W=16.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: req vector, pointer, enable.
  - Output: one-hot grant plus binary index.
  - Purely combinational.

Test Plan:
- Single request: requester 2 sends A=0xFF, B=0xFF, op ADD → req_ready[2] for 1 cycle; rsp_valid 3 cycles later with rsp_id=2, rsp_data=0x1FE.
- SUB wrap: A=0x05, B=0x0A, op SUB → rsp_data=0x1FB. AND: 0xF0 & 0x3C → 0x030. OR: 0xF0 | 0x0F → 0x0FF.
- All four requesters valid from reset with rsp_ready=1 → grant order 0,1,2,3,0; responses spaced 4 cycles apart; each rsp_id matches its operands.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid/rsp_id/rsp_data stable and req_ready stays 0. After rsp_ready=1, rsp_valid drops and the next grant comes 1 cycle later.
- Reset asserted during WAIT → all outputs reach reset values immediately; no response appears. After release, requester 0 is granted first.
- With ALU_SCHED_STATS_EN defined: 3 completed ops → op_count=3. With the counter forced to 0xFFFF, one more op → op_count stays 0xFFFF.
